alu_issue_queue: RTL and testbench

Command buffer and result-capture stage wrapped around the combinational ALU. Accepts operation requests (operands plus 3-bit function code) over a valid/ready handshake and buffers them in a FIFO. It presents the head entry to the ALU, then registers the ALU's result and NZCV flags into an output stage with its own valid/ready handshake. It also keeps a sticky overflow flag and a retired-operation counter for software status.

---
 rtl/alu_issue_queue.sv | 125 ++++++++++++
 tb/tb_alu_issue_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Operation FIFO in front of an external combinational ALU, with a registered
// result stage, a sticky overflow flag and a retired-operation counter.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_a,
  input  logic [31:0]             in_b,
  input  logic [2:0]              in_f,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_f,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_overflow,
  input  logic                    alu_carry,
  input  logic                    alu_negative,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [3:0]              out_flags,
  output logic                    out_err,
  output logic                    sticky_ovf,
  input  logic                    clr_sticky,
  output logic [CNT_W-1:0]        retired,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [31:0]   r_memA [DEPTH];
  logic [31:0]   r_memB [DEPTH];
  logic [2:0]    r_memF [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_level;

  logic             r_outValid;
  logic [31:0]      r_outResult;
  logic [3:0]       r_outFlags;
  logic             r_outErr;
  logic             r_sticky;
  logic [CNT_W-1:0] r_retired;

  logic w_empty;
  logic w_push;
  logic w_load;
  logic w_legal;

  assign w_empty  = (r_level == '0);
  assign in_ready = (r_level != FULL_LEVEL);
  assign w_push   = in_valid && in_ready;
  assign w_load   = !w_empty && (!r_outValid || out_ready);

  assign alu_a = w_empty ? '0 : r_memA[r_rdPtr];
  assign alu_b = w_empty ? '0 : r_memB[r_rdPtr];
  assign alu_f = w_empty ? '0 : r_memF[r_rdPtr];

  always_comb begin
    case (alu_f)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: w_legal = 1'b1;
      default:                                w_legal = 1'b0;
    endcase
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memA[r_wrPtr] <= in_a;
      r_memB[r_wrPtr] <= in_b;
      r_memF[r_wrPtr] <= in_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_outValid  <= 1'b0;
      r_outResult <= '0;
      r_outFlags  <= '0;
      r_outErr    <= 1'b0;
      r_sticky    <= 1'b0;
      r_retired   <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_load) r_rdPtr <= r_rdPtr + AW'(1);

      case ({w_push, w_load})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase

      // Illegal codes still retire in order but report a zeroed result.
      if (w_load) begin
        r_outValid  <= 1'b1;
        r_outResult <= w_legal ? alu_result : '0;
        r_outFlags  <= w_legal ? {alu_negative, alu_zero, alu_carry, alu_overflow} : 4'b0000;
        r_outErr    <= !w_legal;
        r_retired   <= r_retired + CNT_W'(1);
      end else if (out_ready) begin
        r_outValid  <= 1'b0;
      end

      if (w_load && w_legal && alu_overflow) r_sticky <= 1'b1;
      else if (clr_sticky)                   r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_outValid;
  assign out_result = r_outResult;
  assign out_flags  = r_outFlags;
  assign out_err    = r_outErr;
  assign sticky_ovf = r_sticky;
  assign retired    = r_retired;
  assign level      = r_level;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: drives the external ALU from a reference
// function and checks every cycle against a queue-based model.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_f = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_f;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow, alu_carry, alu_negative;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic        sticky_ovf;
  logic        clr_sticky = 1'b0;
  logic [CNT_W-1:0] retired;
  logic [$clog2(DEPTH):0] level;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .alu_negative(alu_negative),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .retired(retired), .level(level)
  );

  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b011) || (f == 3'b101);
  endfunction

  // Returns {result, N, Z, C, V}; illegal codes give junk the DUT must mask.
  function automatic logic [35:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (f)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                    v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                    v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return {32'hBAD0BAD0, 4'b1111};
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  always_comb begin
    {alu_result, alu_negative, alu_zero, alu_carry, alu_overflow} = aluRef(alu_a, alu_b, alu_f);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
  } opT;

  opT          mQ[$];
  bit          mOutValid = 1'b0;
  logic [31:0] mResult = '0;
  logic [3:0]  mFlags = '0;
  bit          mErr = 1'b0;
  bit          mSticky = 1'b0;
  int          mRetired = 0;

  always @(negedge rst_n) begin
    mQ.delete();
    mOutValid = 1'b0; mResult = '0; mFlags = '0; mErr = 1'b0; mSticky = 1'b0; mRetired = 0;
  end

  // Model advances on each edge using the inputs that were stable before it.
  always @(posedge clk) begin
    if (rst_n) begin
      bit doPush, doLoad, setOvf;
      opT h;
      logic [35:0] g;
      doPush = in_valid && (mQ.size() < DEPTH);
      doLoad = (mQ.size() != 0) && (!mOutValid || out_ready);
      setOvf = 1'b0;
      if (doLoad) begin
        h = mQ.pop_front();
        g = aluRef(h.a, h.b, h.f);
        mOutValid = 1'b1;
        mRetired  = (mRetired + 1) % (1 << CNT_W);
        if (isLegal(h.f)) begin
          mResult = g[35:4]; mFlags = g[3:0]; mErr = 1'b0; setOvf = g[0];
        end else begin
          mResult = '0; mFlags = '0; mErr = 1'b1;
        end
      end else if (out_ready) begin
        mOutValid = 1'b0;
      end
      if (setOvf) mSticky = 1'b1;
      else if (clr_sticky) mSticky = 1'b0;
      if (doPush) mQ.push_back('{a: in_a, b: in_b, f: in_f});
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready", 64'(in_ready), 64'(mQ.size() < DEPTH));
      checkOutput("level", 64'(level), 64'(mQ.size()));
      checkOutput("out_valid", 64'(out_valid), 64'(mOutValid));
      if (mOutValid) begin
        checkOutput("out_result", 64'(out_result), 64'(mResult));
        checkOutput("out_flags", 64'(out_flags), 64'(mFlags));
        checkOutput("out_err", 64'(out_err), 64'(mErr));
      end
      checkOutput("sticky_ovf", 64'(sticky_ovf), 64'(mSticky));
      checkOutput("retired", 64'(retired), 64'(mRetired));
      if (mQ.size() != 0) begin
        checkOutput("alu_a", 64'(alu_a), 64'(mQ[0].a));
        checkOutput("alu_b", 64'(alu_b), 64'(mQ[0].b));
        checkOutput("alu_f", 64'(alu_f), 64'(mQ[0].f));
      end else begin
        checkOutput("alu_idle", 64'({alu_a, alu_b, alu_f}), 64'd0);
      end
    end
  end

  // Holds the request until accepted; enters and leaves at posedge+1.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_f = f;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #3;
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected acceptance within 50 cycles");
    end
    in_valid = 1'b0; in_f = 3'bxxx;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset_level", 64'(level), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_retired", 64'(retired), 64'd0);
    rst_n = 1'b1;
    checkEn = 1'b1;
    @(posedge clk); #1;

    // Single overflowing ADD, latency of two edges after accept
    applyStimulus(32'h7FFFFFFF, 32'd1, 3'b000);
    @(negedge clk);
    checkOutput("add_not_yet_valid", 64'(out_valid), 64'd0);
    checkOutput("add_head_a", 64'(alu_a), 64'h7FFFFFFF);
    @(negedge clk);
    checkOutput("add_valid", 64'(out_valid), 64'd1);
    checkOutput("add_result", 64'(out_result), 64'h80000000);
    checkOutput("add_flags", 64'(out_flags), 64'b1001);
    checkOutput("add_sticky", 64'(sticky_ovf), 64'd1);
    checkOutput("add_retired", 64'(retired), 64'd1);
    @(posedge clk); #1;

    // SUB then SLT back to back
    applyStimulus(32'd5, 32'd5, 3'b001);
    applyStimulus(32'hFFFFFFFF, 32'd1, 3'b101);
    @(negedge clk);
    checkOutput("sub_result", 64'(out_result), 64'd0);
    checkOutput("sub_flags", 64'(out_flags), 64'b0110);
    @(negedge clk);
    checkOutput("slt_result", 64'(out_result), 64'd1);
    idleCycles(3);
    checkOutput("b2b_level", 64'(level), 64'd0);

    // Backpressure fill, then drain in order
    out_ready = 1'b0;
    applyStimulus(32'd1, 32'd2, 3'b000);
    applyStimulus(32'd10, 32'd3, 3'b001);
    applyStimulus(32'h0000F0F0, 32'h0000FF00, 3'b010);
    applyStimulus(32'h00000F00, 32'h000000F0, 3'b011);
    applyStimulus(32'd3, 32'hFFFFFFFE, 3'b101);
    @(negedge clk);
    checkOutput("full_level", 64'(level), 64'd4);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_held_result", 64'(out_result), 64'd3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(32'd100, 32'd200, 3'b000);
    idleCycles(8);
    checkOutput("drain_retired", 64'(retired), 64'd9);
    checkOutput("drain_level", 64'(level), 64'd0);

    // Illegal code between two ORs
    applyStimulus(32'd3, 32'd4, 3'b011);
    applyStimulus(32'd3, 32'd4, 3'b100);
    applyStimulus(32'd3, 32'd4, 3'b011);
    @(negedge clk);
    checkOutput("illegal_result", 64'(out_result), 64'd0);
    checkOutput("illegal_flags", 64'(out_flags), 64'd0);
    checkOutput("illegal_err", 64'(out_err), 64'd1);
    checkOutput("illegal_sticky", 64'(sticky_ovf), 64'd1);
    @(negedge clk);
    checkOutput("or_result", 64'(out_result), 64'd7);
    checkOutput("or_err", 64'(out_err), 64'd0);
    idleCycles(2);

    // Set wins over clear, then clear alone
    applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 3'b000);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    checkOutput("set_wins_sticky", 64'(sticky_ovf), 64'd1);
    checkOutput("set_wins_result", 64'(out_result), 64'hFFFFFFFE);
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    checkOutput("clear_sticky", 64'(sticky_ovf), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset with ops queued and a held result
    out_ready = 1'b0;
    applyStimulus(32'h7FFFFFFF, 32'd1, 3'b000);
    applyStimulus(32'd1, 32'd1, 3'b000);
    applyStimulus(32'd2, 32'd2, 3'b000);
    applyStimulus(32'd3, 32'd3, 3'b000);
    checkOutput("pre_reset_level", 64'(level), 64'd3);
    checkOutput("pre_reset_sticky", 64'(sticky_ovf), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_level", 64'(level), 64'd0);
    checkOutput("async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_retired", 64'(retired), 64'd0);
    checkOutput("async_sticky", 64'(sticky_ovf), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'd2, 32'd3, 3'b000);
    @(negedge clk);
    checkOutput("post_reset_idle", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("post_reset_result", 64'(out_result), 64'd5);
    checkOutput("post_reset_retired", 64'(retired), 64'd1);
    idleCycles(3);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
